// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: register offsets, status bits, FSM states.
package uart_rx_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned ADDR_W = 2;

    // Register offsets
    localparam logic [ADDR_W-1:0] UART_REG_DATA   = 2'd0;
    localparam logic [ADDR_W-1:0] UART_REG_STATUS = 2'd1;
    localparam logic [ADDR_W-1:0] UART_REG_CLEAR  = 2'd2;

    // Status bit positions
    localparam int unsigned ST_NOT_EMPTY = 0;
    localparam int unsigned ST_OVERRUN   = 1;
    localparam int unsigned ST_FRAME_ERR = 2;

    // Receiver FSM states
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } rx_state_e;

    // Pack the status register from its individual flags.
    function automatic logic [DATA_W-1:0] status_byte(
        input logic not_empty,
        input logic overrun,
        input logic frame_err
    );
        logic [DATA_W-1:0] s;
        s = '0;
        s[ST_NOT_EMPTY] = not_empty;
        s[ST_OVERRUN]   = overrun;
        s[ST_FRAME_ERR] = frame_err;
        return s;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small byte FIFO for received data; wrap-bit pointers, synchronous reset.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_c,
    output logic              full_c,
    output logic              empty_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              push_ok;
    logic              pop_ok;

    // Occupancy decode and pointer advance; a pop frees a slot for a same-cycle push.
    always_comb begin
        empty_c  = (wr_ptr_q == rd_ptr_q);
        full_c   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        head_c   = mem_q[rd_ptr_q[AW-1:0]];
        pop_ok   = pop && !empty_c;
        push_ok  = push && (!full_c || pop_ok);
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with byte FIFO, status flags and CPU register interface.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DIVISOR    = 104,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rx,
    output logic              irq
);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(DIVISOR - 1);

    // Synchronizer
    logic rx_meta_q, rx_meta_d;
    logic rxs_q, rxs_d;

    // Receiver FSM
    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              cnt_zero_c;
    logic              stop_ok_c;
    logic              stop_bad_c;

    // Flags and bus outputs
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              irq_q, irq_d;

    // FIFO interface
    logic              push_c;
    logic              pop_c;
    logic [DATA_W-1:0] head_c;
    logic              full_c;
    logic              empty_c;
    logic              wr_req_c;
    logic              clr_ovr_c;
    logic              clr_ferr_c;
    logic              unused_wr_bits;

    assign unused_wr_bits = ^{wr_data[7:3], wr_data[0]};

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (shift_q),
        .pop       (pop_c),
        .head_c    (head_c),
        .full_c    (full_c),
        .empty_c   (empty_c)
    );

    // Two-stage synchronizer feed.
    always_comb begin
        rx_meta_d = rx;
        rxs_d     = rx_meta_q;
    end

    // Frame recovery: mid-bit sampling driven by a down-counting baud counter.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        stop_ok_c  = 1'b0;
        stop_bad_c = 1'b0;
        cnt_zero_c = (cnt_q == '0);

        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    cnt_d   = HALF_LOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_zero_c) begin
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d     = BIT_LOAD;
                        bit_idx_d = '0;
                        state_d   = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_zero_c) begin
                    shift_d   = {rxs_q, shift_q[DATA_W-1:1]};
                    cnt_d     = BIT_LOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_zero_c) begin
                    if (rxs_q) begin
                        stop_ok_c = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        stop_bad_c = 1'b1;
                        state_d    = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register interface, FIFO push/pop arbitration and sticky error flags.
    always_comb begin
        rd_data_d  = '0;
        rd_valid_d = rd_en;
        wr_req_c   = wr_en && !rd_en;
        pop_c      = rd_en && (addr == UART_REG_DATA) && !empty_c;
        push_c     = stop_ok_c && (!full_c || pop_c);
        clr_ovr_c  = wr_req_c && (addr == UART_REG_CLEAR) && wr_data[ST_OVERRUN];
        clr_ferr_c = wr_req_c && (addr == UART_REG_CLEAR) && wr_data[ST_FRAME_ERR];

        if (rd_en) begin
            case (addr)
                UART_REG_DATA:   rd_data_d = empty_c ? '0 : head_c;
                UART_REG_STATUS: rd_data_d = status_byte(!empty_c, overrun_q, frame_err_q);
                default:         rd_data_d = '0;
            endcase
        end

        overrun_d   = (stop_ok_c && full_c && !pop_c) || (overrun_q && !clr_ovr_c);
        frame_err_d = stop_bad_c || (frame_err_q && !clr_ferr_c);
        irq_d       = !empty_c || overrun_q || frame_err_q;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rxs_q       <= rxs_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            irq_q       <= irq_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign irq      = irq_q;

endmodule
